// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch/PC stage: branch kind codes, FSM states and
// default address map.
package fetch_pc_unit_pkg;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0040_0000;
  localparam int unsigned DEF_IMEM_WORDS = 1024;

  typedef enum logic [3:0] {
    BR_SEQ  = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLTZ = 4'd3,
    BR_BGEZ = 4'd4,
    BR_BLEZ = 4'd5,
    BR_BGTZ = 4'd6,
    BR_J    = 4'd7,
    BR_JR   = 4'd8
  } br_kind_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_branch_cond.sv
// Branch condition evaluation: decides whether a conditional branch is taken.
// Unconditional kinds (J/JR) and SEQ report not-taken; the top handles them.
module fetch_pc_unit_branch_cond
  import fetch_pc_unit_pkg::*;
(
  input  logic [3:0]  br_kind,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        taken
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs_val[31];
  assign rs_zero = (rs_val == 32'd0);

  always_comb begin
    taken = 1'b0;
    case (br_kind)
      BR_BEQ:  taken = (rs_val == rt_val);
      BR_BNE:  taken = (rs_val != rt_val);
      BR_BLTZ: taken = rs_neg;
      BR_BGEZ: taken = !rs_neg;
      BR_BLEZ: taken = rs_neg || rs_zero;
      BR_BGTZ: taken = !rs_neg && !rs_zero;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch stage: fetches one word, waits for execute
// to resolve the next PC, and halts permanently on an illegal next PC.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int unsigned IMEM_WORDS = DEF_IMEM_WORDS
) (
  input  logic        CLK,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        br_valid,
  input  logic [3:0]  br_kind,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [15:0] imm16,
  input  logic [25:0] jtarget,
  output logic [31:0] pc,
  output logic        invpc,
  output logic [31:0] retired
);

  localparam logic [31:0] PC_LIMIT = RESET_PC + 32'(4 * IMEM_WORDS);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic         invpc_q, invpc_d;
  logic [31:0]  retired_q, retired_d;

  logic        taken;
  logic [31:0] p4;
  logic [31:0] bt;
  logic [31:0] npc;
  logic        npc_bad;

  fetch_pc_unit_branch_cond u_branch_cond (
    .br_kind (br_kind),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .taken   (taken)
  );

  assign p4 = pc_q + 32'd4;
  assign bt = p4 + branch_offset(imm16);

  always_comb begin
    npc = p4;
    case (br_kind)
      BR_BEQ, BR_BNE, BR_BLTZ, BR_BGEZ, BR_BLEZ, BR_BGTZ: npc = taken ? bt : p4;
      BR_J:    npc = {p4[31:28], jtarget, 2'b00};
      BR_JR:   npc = rs_val;
      default: npc = p4;
    endcase
  end

  // A wrapped p4 (0) falls below RESET_PC and is caught by the low bound.
  assign npc_bad = (npc[1:0] != 2'b00) || (npc < RESET_PC) || (npc >= PC_LIMIT);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    invpc_d       = invpc_q;
    retired_d     = retired_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (br_valid) begin
          retired_d     = retired_q + 32'd1;
          instr_valid_d = 1'b0;
          if (npc_bad) begin
            invpc_d = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d    = npc;
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
        instr_valid_d = 1'b0;
        invpc_d       = 1'b1;
        state_d       = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      invpc_q       <= 1'b0;
      retired_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      invpc_q       <= invpc_d;
      retired_q     <= retired_d;
    end
  end

  // Request is suppressed while reset is held so nothing is fetched mid-reset.
  assign imem_req    = (state_q == ST_FETCH) && !reset;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign invpc       = invpc_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized
// instruction streams against a behavioural next-PC model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RPC   = 32'h0040_0000;
  localparam int unsigned WORDS = 1024;

  logic        CLK;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        br_valid;
  logic [3:0]  br_kind;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [15:0] imm16;
  logic [25:0] jtarget;
  logic [31:0] pc;
  logic        invpc;
  logic [31:0] retired;

  fetch_pc_unit #(.RESET_PC(RPC), .IMEM_WORDS(WORDS)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .br_valid    (br_valid),
    .br_kind     (br_kind),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .imm16       (imm16),
    .jtarget     (jtarget),
    .pc          (pc),
    .invpc       (invpc),
    .retired     (retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_halt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_npc(input logic [3:0] k, input logic [31:0] cur,
                                          input logic [31:0] rs, input logic [31:0] rt,
                                          input logic [15:0] imm, input logic [25:0] jt);
    longint p4l = longint'(cur) + 4;
    longint btl = p4l + 4 * longint'($signed(imm));
    logic [31:0] p4w = 32'(p4l);
    int s = $signed(rs);
    bit take = 0;
    case (k)
      4'd1: take = (rs == rt);
      4'd2: take = (rs != rt);
      4'd3: take = (s < 0);
      4'd4: take = (s >= 0);
      4'd5: take = (s <= 0);
      4'd6: take = (s > 0);
      4'd7: return (p4w & 32'hF000_0000) | (32'(jt) * 4);
      4'd8: return rs;
      default: take = 0;
    endcase
    return take ? 32'(btl) : p4w;
  endfunction

  function automatic bit ref_legal(input logic [31:0] a);
    return (a % 4 == 0) && (longint'(a) >= longint'(RPC)) &&
           (longint'(a) < longint'(RPC) + 4 * longint'(WORDS));
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1;
    imem_ready = 1'b0;
    br_valid = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ivalid", 32'(instr_valid), 32'd0);
    chk("rst_invpc", 32'(invpc), 32'd0);
    chk("rst_retired", retired, 32'd0);
    @(negedge CLK);
    reset = 1'b0;
    #1;
    chk("post_rst_req", 32'(imem_req), 32'd1);
    m_pc = RPC;
    m_ret = 32'd0;
    m_halt = 1'b0;
  endtask

  // One full fetch + execute; rdly = cycles imem_ready stays low, edly = cycles before br_valid.
  task automatic run_instr(input logic [3:0] k, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [15:0] imm, input logic [25:0] jt,
                           input int rdly, input int edly);
    logic [31:0] data;
    logic [31:0] exp_npc;
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, m_pc);
    for (int i = 0; i < rdly; i++) begin
      imem_ready = 1'b0;
      br_valid = 1'($urandom_range(0, 1));
      @(negedge CLK);
      chk("wait_ivalid", 32'(instr_valid), 32'd0);
      chk("wait_pc", pc, m_pc);
      chk("wait_req", 32'(imem_req), 32'd1);
    end
    data = $urandom;
    imem_ready = 1'b1;
    imem_rdata = data;
    br_valid = 1'($urandom_range(0, 1));
    @(negedge CLK);
    imem_ready = 1'($urandom_range(0, 1));
    br_valid = 1'b0;
    imem_rdata = $urandom;
    chk("instr", instr, data);
    chk("ivalid_hi", 32'(instr_valid), 32'd1);
    chk("exec_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < edly; i++) begin
      @(negedge CLK);
      chk("exec_hold_ivalid", 32'(instr_valid), 32'd1);
      chk("exec_hold_pc", pc, m_pc);
    end
    br_kind = k;
    rs_val = rs;
    rt_val = rt;
    imm16 = imm;
    jtarget = jt;
    br_valid = 1'b1;
    @(negedge CLK);
    br_valid = 1'b0;
    imem_ready = 1'b0;
    exp_npc = ref_npc(k, m_pc, rs, rt, imm, jt);
    m_ret = m_ret + 32'd1;
    if (ref_legal(exp_npc)) m_pc = exp_npc;
    else m_halt = 1'b1;
    chk("npc", pc, m_pc);
    chk("retired", retired, m_ret);
    chk("invpc", 32'(invpc), 32'(m_halt));
    chk("ivalid_lo", 32'(instr_valid), 32'd0);
    chk("next_req", 32'(imem_req), 32'(!m_halt));
  endtask

  task automatic halt_hold();
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b1;
      br_valid = 1'b1;
      br_kind = 4'd0;
      @(negedge CLK);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_pc", pc, m_pc);
      chk("halt_invpc", 32'(invpc), 32'd1);
      chk("halt_ivalid", 32'(instr_valid), 32'd0);
      chk("halt_retired", retired, m_ret);
    end
    imem_ready = 1'b0;
    br_valid = 1'b0;
  endtask

  initial begin
    logic [3:0]  k;
    logic [31:0] rs, rt;
    logic [15:0] imm;
    logic [25:0] jt;
    reset = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    br_valid = 1'b0;
    br_kind = 4'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;
    imm16 = 16'd0;
    jtarget = 26'd0;

    // sequential at full rate
    do_reset();
    run_instr(4'd0, 32'd0, 32'd0, 16'd0, 26'd0, 0, 0);
    chk("seq_pc1", pc, 32'h0040_0004);
    run_instr(4'd0, 32'd0, 32'd0, 16'd0, 26'd0, 0, 0);
    run_instr(4'd3, 32'hFFFF_FFFC, 32'd0, 16'hFFFE, 26'd0, 0, 0);
    chk("bltz_taken", pc, 32'h0040_0004);
    do_reset();
    run_instr(4'd0, 32'd0, 32'd0, 16'd0, 26'd0, 0, 0);
    run_instr(4'd0, 32'd0, 32'd0, 16'd0, 26'd0, 0, 0);
    run_instr(4'd3, 32'd4, 32'd0, 16'hFFFE, 26'd0, 0, 1);
    chk("bltz_not", pc, 32'h0040_000C);

    do_reset();
    run_instr(4'd4, 32'd0, 32'd0, 16'd1, 26'd0, 0, 0);
    chk("bgez_zero", pc, 32'h0040_0008);
    do_reset();
    run_instr(4'd6, 32'd0, 32'd0, 16'd1, 26'd0, 0, 0);
    chk("bgtz_zero", pc, 32'h0040_0004);
    run_instr(4'd1, 32'hAA, 32'hAA, 16'd3, 26'd0, 1, 0);
    chk("beq_taken", pc, 32'h0040_0014);

    do_reset();
    run_instr(4'd7, 32'd0, 32'd0, 16'd0, 26'h010_0004, 3, 0);
    chk("j_target", pc, 32'h0040_0010);

    run_instr(4'd8, 32'h0040_0002, 32'd0, 16'd0, 26'd0, 0, 0);
    chk("jr_misalign_halt", 32'(invpc), 32'd1);
    halt_hold();
    do_reset();

    // upper boundary: last legal word then fall off the end
    run_instr(4'd8, 32'h0040_0FFC, 32'd0, 16'd0, 26'd0, 0, 0);
    chk("jr_last_word", pc, 32'h0040_0FFC);
    run_instr(4'd0, 32'd0, 32'd0, 16'd0, 26'd0, 0, 0);
    chk("seq_past_end", 32'(invpc), 32'd1);
    halt_hold();
    do_reset();
    // lower boundary
    run_instr(4'd3, 32'h8000_0000, 32'd0, 16'hFFFF, 26'd0, 0, 0);
    chk("back_to_base", pc, RPC);
    run_instr(4'd5, 32'd0, 32'd0, 16'hFFFE, 26'd0, 0, 0);
    chk("below_base", 32'(invpc), 32'd1);
    halt_hold();

    // reset while fetch is waiting on memory
    do_reset();
    run_instr(4'd0, 32'd0, 32'd0, 16'd0, 26'd0, 0, 0);
    imem_ready = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_pc", pc, RPC);
    chk("mid_rst_ret", retired, 32'd0);
    @(negedge CLK);
    reset = 1'b0;
    #1;
    m_pc = RPC;
    m_ret = 32'd0;
    m_halt = 1'b0;
    run_instr(4'd0, 32'd0, 32'd0, 16'd0, 26'd0, 0, 0);
    chk("refetch_pc", pc, 32'h0040_0004);

    // randomized streams
    for (int n = 0; n < 300; n++) begin
      k = 4'($urandom_range(0, 15));
      rt = $urandom;
      case ($urandom_range(0, 3))
        0: rs = 32'd0;
        1: rs = $urandom;
        2: rs = 32'($urandom_range(1, 5));
        default: rs = 32'(-$urandom_range(1, 5));
      endcase
      if ($urandom_range(0, 3) == 0) rt = rs;
      imm = 16'($urandom_range(0, 40) - 20);
      jt = 26'((RPC >> 2) + $urandom_range(0, 1100));
      if (k == 4'd8) begin
        rs = RPC + 32'(4 * $urandom_range(0, 1100));
        if ($urandom_range(0, 7) == 0) rs = rs + 32'($urandom_range(1, 3));
      end
      run_instr(k, rs, rt, imm, jt, $urandom_range(0, 2), $urandom_range(0, 2));
      if (m_halt) begin
        halt_hold();
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
